count_sched: RTL
================

COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8: width of the shared counter.
REQ-002 The block SHALL have parameter BURST, default 4: counter increments per grant, legal range 1..255.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req  input  4  request, one bit per requester, level-sensitive.
REQ-006 The block SHALL have port cnt_clr  input  1  synchronous clear of the shared counter.
REQ-007 The block SHALL have port gnt  output  4  one-hot grant; all zero when no owner.
REQ-008 The block SHALL have port cnt  output  CNT_W  shared counter value.
REQ-009 The block SHALL have port busy  output  1  high while in the GRANT state.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse at the end of each grant.
REQ-011 The block SHALL have port done_id  output  2  index of the requester whose grant ended; valid when done=1.

Function
REQ-012 The block SHALL implement three states:
- IDLE
- GRANT
- RELEASE
REQ-013 In IDLE with any req bit set, the block SHALL select the first set bit at or after the 2-bit round-robin pointer ptr, searching upward modulo 4.
- Next cycle: state=GRANT, gnt=one-hot(winner), busy=1, beat=0.
- Latency from req to gnt: exactly 1 cycle.
REQ-014 In IDLE with req=0, the block SHALL remain in IDLE with gnt=0.
REQ-015 In GRANT, each cycle the block SHALL increment cnt by 1 modulo 2^CNT_W and increment an 8-bit beat counter.
- Wrap: all-ones to 0, with no flag.
REQ-016 When beat==BURST-1 in GRANT, the block SHALL move to RELEASE on the next edge.
- In that cycle: gnt=0, busy=0, done=1, done_id=winner, ptr=winner+1 modulo 4 (3 wraps to 0).
- Each grant produces exactly BURST increments.
REQ-017 RELEASE SHALL last exactly one cycle and then return to IDLE.
- No grant is issued from RELEASE.
- Minimum spacing gnt-fall to next gnt-rise: 2 cycles.
REQ-018 The block SHALL ignore changes on req during GRANT, except as given in REQ-024.
REQ-019 The block SHALL honour cnt_clr only in IDLE (cnt becomes 0 next cycle) and ignore it in GRANT and RELEASE.
- If a grant is issued in the same cycle as the clear, cnt SHALL hold 0 on the first GRANT cycle.
REQ-020 gnt SHALL never have more than one bit set.
REQ-021 done SHALL never be high for two consecutive cycles.

Reset
REQ-022 On assertion of reset (low), the block SHALL asynchronously drive:
- state=IDLE
- gnt=0, cnt=0, busy=0, done=0, done_id=0
- ptr=0, beat=0
REQ-023 Reset asserted mid-GRANT SHALL abort the grant with no done pulse. After deassertion, arbitration SHALL restart from ptr=0 on the first rising edge.

Configuration
REQ-024 With macro COUNT_SCHED_EARLY_REL_EN defined, the block SHALL end a grant early when the owner's req bit is 0 during GRANT.
- Next cycle: state=RELEASE, done=1 with done_id=owner, ptr=owner+1.
- No cnt increment in the cycle req is sampled low.
REQ-025 Without COUNT_SCHED_EARLY_REL_EN, every grant SHALL run the full BURST cycles regardless of req.

Verification
REQ-026 The bench SHALL cover single requester:
- Stimulus: req=0001, BURST=4, from reset.
- Response: gnt=0001 one cycle later for 4 cycles, cnt 0->4, done=1 with done_id=0, then gnt=0.
REQ-027 The bench SHALL cover round robin:
- Stimulus: req=1111 held.
- Response: grant order 0,1,2,3,0; each grant 4 cycles; cnt=20 after the fifth done.
REQ-028 The bench SHALL cover pointer wrap:
- Stimulus: ptr=3 after a grant to 2, then req=0101.
- Response: next grant goes to 0, then 2.
REQ-029 The bench SHALL cover counter wrap:
- Stimulus: CNT_W=8, cnt=254, one grant with BURST=4.
- Response: cnt sequence 255,0,1,2.
REQ-030 The bench SHALL cover reset mid-grant:
- Stimulus: reset low on the 2nd GRANT cycle.
- Response: gnt=0 and cnt=0 immediately, no done pulse; after release with req=0010, gnt=0010.
REQ-031 The bench SHALL cover early release, with COUNT_SCHED_EARLY_REL_EN defined:
- Stimulus: owner 1 drops req after 2 increments.
- Response: done=1 with done_id=1 next cycle; cnt advanced by 2; next grant searches from requester 2.
- Without the macro: the same stimulus gives 4 increments.

Source files
------------

// File: rtl/count_sched.sv
// ----------------------------------------------------------------------------
// count_sched -- four-way round-robin scheduler that lends a shared counter
// to one requester at a time.
//
// Each grant owns the counter for BURST cycles. The counter advances by one
// per owned cycle and wraps silently. A one-cycle RELEASE gap always follows
// a grant; it carries the done pulse and advances the round-robin pointer
// past the requester that was just served.
//
// Parameters
//   CNT_W    width of the shared counter (default 8)
//   BURST    counter increments per grant, 1..255 (default 4)
//
// Ports
//   clk      input            rising-edge clock
//   reset    input            asynchronous, active-low reset
//   req      input  [3:0]     level-sensitive requests, one bit per requester
//   cnt_clr  input            synchronous counter clear, honoured in IDLE only
//   gnt      output [3:0]     one-hot grant, zero when nobody owns the counter
//   cnt      output [CNT_W-1:0] shared counter
//   busy     output           high while in GRANT
//   done     output           one-cycle pulse as a grant ends
//   done_id  output [1:0]     requester whose grant ended (valid with done)
//
// Build option
//   COUNT_SCHED_EARLY_REL_EN  when defined, a grant ends early as soon as the
//                             owner's req bit is sampled low during GRANT;
//                             that cycle does not advance the counter.
// ----------------------------------------------------------------------------
module count_sched #(
    parameter int CNT_W = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic             cnt_clr,
    output logic [3:0]       gnt,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic [1:0]       done_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0]       BEAT_LAST = 8'(BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    generate
        if ((BURST < 1) || (BURST > 255)) begin : g_bad_burst
            $error("count_sched: BURST must lie in 1..255");
        end
    endgenerate

    // First set request at or after the pointer, searching upward mod 4.
    // Only meaningful when r is non-zero; otherwise returns the pointer.
    function automatic logic [1:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = p;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    // Counter advance: modulo 2^CNT_W, wrap is intentionally silent.
    function automatic logic [CNT_W-1:0] cnt_wrap_inc(input logic [CNT_W-1:0] c);
        return c + CNT_ONE;
    endfunction

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [1:0]       owner, owner_nxt;
    logic [7:0]       beat, beat_nxt;
    logic [3:0]       gnt_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [1:0]       done_id_nxt;
    logic             owner_drop;

`ifdef COUNT_SCHED_EARLY_REL_EN
    assign owner_drop = ~req[owner];
`else
    assign owner_drop = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            owner   <= 2'd0;
            beat    <= 8'd0;
            gnt     <= 4'd0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 2'd0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            owner   <= owner_nxt;
            beat    <= beat_nxt;
            gnt     <= gnt_nxt;
            cnt     <= cnt_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            done_id <= done_id_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        owner_nxt   = owner;
        beat_nxt    = beat;
        gnt_nxt     = 4'd0;
        cnt_nxt     = cnt;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        done_id_nxt = done_id;

        unique case (state)
            IDLE: begin
                // A clear and a new grant in the same cycle both apply, so
                // the first GRANT cycle already shows zero.
                if (cnt_clr) begin
                    cnt_nxt = '0;
                end
                if (|req) begin
                    owner_nxt = rr_pick(req, ptr);
                    gnt_nxt   = onehot4(rr_pick(req, ptr));
                    busy_nxt  = 1'b1;
                    beat_nxt  = 8'd0;
                    state_nxt = GRANT;
                end
            end

            GRANT: begin
                if (owner_drop) begin
                    // Early end: the cycle that sees the dropped request
                    // does not count.
                    state_nxt   = RELEASE;
                    done_nxt    = 1'b1;
                    done_id_nxt = owner;
                    ptr_nxt     = owner + 2'd1;
                end else begin
                    cnt_nxt  = cnt_wrap_inc(cnt);
                    beat_nxt = beat + 8'd1;
                    if (beat == BEAT_LAST) begin
                        state_nxt   = RELEASE;
                        done_nxt    = 1'b1;
                        done_id_nxt = owner;
                        ptr_nxt     = owner + 2'd1;
                    end else begin
                        gnt_nxt  = gnt;
                        busy_nxt = 1'b1;
                    end
                end
            end

            RELEASE: begin
                // Mandatory one-cycle gap; requests are not looked at here.
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifndef SYNTHESIS
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!reset)
                                     $onehot0(gnt));
    a_done_single : assert property (@(posedge clk) disable iff (!reset)
                                     !(done && $past(done)));
`endif

endmodule
